// File: rtl/id_operand_stage.sv
// Decode/operand stage: one-instruction slot, priority bypass network, load-use stall.
// Optional perf counters are enabled by defining ID_PERF_CNT_EN.
module id_operand_stage #(
    parameter int NUM_FWD = 3,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_pc,
    output logic                      in_ready,
    input  logic [31:0]               inst_rdata,
    output logic [REG_AW-1:0]         rf_raddr1,
    output logic [REG_AW-1:0]         rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_pc,
    output logic [31:0]               out_inst,
    output logic [DATA_W-1:0]         out_rs_val,
    output logic [DATA_W-1:0]         out_rt_val,
    output logic                      stallreq
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]               perf_stall_cycles,
    output logic [31:0]               perf_bubbles
`endif
);

    typedef enum logic [1:0] {EMPTY, FRESH, HELD} slot_state_t;

    slot_state_t       state, state_nxt;
    logic [DATA_W-1:0] pc_q;
    logic [31:0]       inst_buf;
    logic              buf_valid, buf_nxt;
    logic              latch_buf;
    logic              slot_valid, fire, capture, hazard;
    logic [31:0]       cur_inst;
    logic              rs_load, rt_load;

    // Returns {selected-match-is-load, value}; lowest index wins and masks the rest.
    function automatic logic [DATA_W:0] resolve(
        input logic [REG_AW-1:0]         addr,
        input logic [DATA_W-1:0]         rf_val,
        input logic [NUM_FWD-1:0]        we,
        input logic [NUM_FWD-1:0]        ld,
        input logic [NUM_FWD*REG_AW-1:0] waddr,
        input logic [NUM_FWD*DATA_W-1:0] wdata
    );
        logic              hit;
        logic              load;
        logic [DATA_W-1:0] val;
        hit  = 1'b0;
        load = 1'b0;
        val  = rf_val;
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!hit && we[i] && (waddr[i*REG_AW +: REG_AW] == addr)) begin
                hit  = 1'b1;
                load = ld[i];
                val  = wdata[i*DATA_W +: DATA_W];
            end
        end
        if (addr == '0) begin
            load = 1'b0;
            val  = '0;
        end
        return {load, val};
    endfunction

    assign slot_valid = (state != EMPTY);
    assign cur_inst   = (state == FRESH) ? inst_rdata :
                        (state == HELD && buf_valid) ? inst_buf : '0;
    assign rf_raddr1  = slot_valid ? cur_inst[25:21] : '0;
    assign rf_raddr2  = slot_valid ? cur_inst[20:16] : '0;

    assign {rs_load, out_rs_val} = resolve(rf_raddr1, rf_rdata1, fwd_we, fwd_is_load, fwd_waddr, fwd_wdata);
    assign {rt_load, out_rt_val} = resolve(rf_raddr2, rf_rdata2, fwd_we, fwd_is_load, fwd_waddr, fwd_wdata);

    assign hazard    = slot_valid & (rs_load | rt_load);
    assign stallreq  = hazard;
    assign out_valid = slot_valid & ~hazard;
    assign fire      = out_valid & out_ready;
    assign in_ready  = (state == EMPTY) | fire;
    assign capture   = in_valid & in_ready & ~flush;
    assign out_pc    = pc_q;
    assign out_inst  = cur_inst;

    always_comb begin
        state_nxt = state;
        buf_nxt   = buf_valid;
        latch_buf = 1'b0;
        case (state)
            EMPTY: if (capture) state_nxt = FRESH;
            FRESH: begin
                if (fire) begin
                    state_nxt = capture ? FRESH : EMPTY;
                    buf_nxt   = 1'b0;
                end else begin
                    // SRAM word is only valid this cycle; keep a copy for longer stalls.
                    state_nxt = HELD;
                    latch_buf = 1'b1;
                    buf_nxt   = 1'b1;
                end
            end
            HELD: begin
                if (fire) begin
                    state_nxt = capture ? FRESH : EMPTY;
                    buf_nxt   = 1'b0;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            buf_nxt   = 1'b0;
            latch_buf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            pc_q      <= '0;
            inst_buf  <= '0;
            buf_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            buf_valid <= buf_nxt;
            if (capture)   pc_q     <= in_pc;
            if (latch_buf) inst_buf <= inst_rdata;
        end
    end

`ifdef ID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_bubbles      <= '0;
        end else begin
            if (stallreq)       perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (state == EMPTY) perf_bubbles      <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule
